// File: rtl/adc_capture_trig.sv
// ADC capture with level/edge trigger into an internal dual-port record buffer.
// Optional pre-trigger history enabled by defining ADC_CAPTURE_PRETRIG_EN.
module adc_capture_trig #(
  parameter int DATA_W  = 14,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int DECIM_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] ADC_Data,
  input  logic              Start,
  input  logic [1:0]        Trig_Mode,
  input  logic [DATA_W-1:0] Trig_Level,
  input  logic [DECIM_W-1:0] Decim,
  input  logic [ADDR_W-1:0] Pre_Cnt,
  input  logic              Rd_En,
  input  logic [ADDR_W-1:0] Rd_Addr,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Start_Addr
);

`ifdef ADC_CAPTURE_PRETRIG_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ARM, CAPT, FIN} state_t;

  state_t              state;
  logic [DECIM_W-1:0]  decim_q;
  logic [DECIM_W-1:0]  cnt;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   level_q;
  logic [ADDR_W-1:0]   pre_q;
  logic [DATA_W-1:0]   cur;
  logic [DATA_W-1:0]   prev;
  logic                have_cur;
  logic                prev_valid;
  logic                smp;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W:0]     post_cnt;
  logic [ADDR_W:0]     pre_seen;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                run;
  logic                tick;
  logic                rise;
  logic                fall;
  logic                hit;
  logic                pre_ok;
  logic                fire;
  logic                we;
  logic [ADDR_W-1:0]   pre_eff;
  logic [ADDR_W:0]     post_len;
  logic [ADDR_W:0]     post_nxt;

  assign run  = (state == ARM) || (state == CAPT);
  assign tick = run && (cnt == decim_q);
  assign rise = prev_valid && (prev < level_q) && (cur >= level_q);
  assign fall = prev_valid && (prev >= level_q) && (cur < level_q);

  always_comb begin
    hit = rise;
    unique case (1'b1)
      mode_q == 2'b00: hit = 1'b1;
      mode_q == 2'b10: hit = fall;
      default:         hit = rise;
    endcase
  end

  // smp marks the cycle in which cur/prev hold a freshly taken sample
  assign pre_eff  = PRE_EN ? pre_q : '0;
  assign pre_ok   = !PRE_EN || (pre_seen >= {1'b0, pre_q});
  assign fire     = (state == ARM) && smp && hit && pre_ok;
  assign we       = smp && ((state == CAPT) || fire ||
                            ((state == ARM) && PRE_EN));
  assign post_len = (ADDR_W+1)'(DEPTH) - {1'b0, pre_eff};
  assign post_nxt = post_cnt + 1'b1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Start_Addr <= '0;
      decim_q    <= '0;
      cnt        <= '0;
      mode_q     <= '0;
      level_q    <= '0;
      pre_q      <= '0;
      cur        <= '0;
      prev       <= '0;
      have_cur   <= 1'b0;
      prev_valid <= 1'b0;
      smp        <= 1'b0;
      wr_addr    <= '0;
      post_cnt   <= '0;
      pre_seen   <= '0;
    end else begin
      smp <= tick;
      if (tick) begin
        cur        <= ADC_Data;
        prev       <= cur;
        have_cur   <= 1'b1;
        prev_valid <= have_cur;
      end
      if (run) cnt <= tick ? '0 : cnt + 1'b1;
      if (we) wr_addr <= wr_addr + 1'b1;
      unique case (state)
        IDLE: begin
          if (Start) begin
            state      <= ARM;
            Busy       <= 1'b1;
            Done       <= 1'b0;
            decim_q    <= Decim;
            mode_q     <= Trig_Mode;
            level_q    <= Trig_Level;
            pre_q      <= Pre_Cnt;
            cnt        <= '0;
            have_cur   <= 1'b0;
            prev_valid <= 1'b0;
            wr_addr    <= '0;
            pre_seen   <= '0;
          end
        end
        ARM: begin
          if (smp && pre_seen != (ADDR_W+1)'(DEPTH))
            pre_seen <= pre_seen + 1'b1;
          if (fire) begin
            Start_Addr <= PRE_EN ? wr_addr - pre_q : '0;
            post_cnt   <= (ADDR_W+1)'(1);
            if (post_len == (ADDR_W+1)'(1)) begin
              state <= FIN;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              state <= CAPT;
            end
          end
        end
        CAPT: begin
          if (smp) begin
            post_cnt <= post_nxt;
            if (post_nxt == post_len) begin
              state <= FIN;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (we) mem[wr_addr] <= cur;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Rd_Data <= '0;
    else if (Rd_En) Rd_Data <= mem[Rd_Addr];
  end

endmodule

// File: tb/tb_adc_capture_trig.sv
// Bench for adc_capture_trig: scenario table plus sample-level model
// and a read scoreboard; handles both pre-trigger builds.
module tb_adc_capture_trig;
  localparam int DW    = 14;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int DCW   = 16;
`ifdef ADC_CAPTURE_PRETRIG_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           Reset;
  logic [DW-1:0]  ADC_Data;
  logic           Start;
  logic [1:0]     Trig_Mode;
  logic [DW-1:0]  Trig_Level;
  logic [DCW-1:0] Decim;
  logic [AW-1:0]  Pre_Cnt;
  logic           Rd_En;
  logic [AW-1:0]  Rd_Addr;
  logic [DW-1:0]  Rd_Data;
  logic           Busy;
  logic           Done;
  logic [AW-1:0]  Start_Addr;

  adc_capture_trig #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .DECIM_W(DCW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ADC_Data(ADC_Data), .Start(Start),
    .Trig_Mode(Trig_Mode), .Trig_Level(Trig_Level), .Decim(Decim),
    .Pre_Cnt(Pre_Cnt), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr),
    .Rd_Data(Rd_Data), .Busy(Busy), .Done(Done), .Start_Addr(Start_Addr)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wave_kind = 3;
  int t_base = 0;
  int done_rises = 0;
  logic done_d = 1'b0;

  int exp_q[$];
  int addr_q[$];

  typedef struct {
    string name;
    int mode;
    int level;
    int decim;
    int wave;
    int pre;
    bit inj;
    int exp_busy;
    int exp_done;
    int exp_rises;
  } scen_t;

  scen_t tbl[6];

  // 0 ramp up, 1 sine (period 100), 2 ramp down, 3 flat 100
  function automatic int wave(int n);
    int t;
    t = n - t_base;
    case (wave_kind)
      0: return t & 16383;
      1: return int'(8192.0 + 8000.0 *
                     $sin(6.283185307179586 * real'(t) / 100.0));
      2: return (t > 16383) ? 0 : 16383 - t;
      default: return 100;
    endcase
  endfunction

  always @(posedge Clk) begin
    cyc++;
    #1 ADC_Data = DW'(wave(cyc));
  end

  always @(negedge Clk) begin
    if (Done && !done_d) done_rises++;
    done_d = Done;
  end

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_read(int a, int e);
    int ex;
    int ad;
    Rd_En = 1'b1;
    Rd_Addr = AW'(a);
    exp_q.push_back(e);
    addr_q.push_back(a);
    @(posedge Clk); #1;
    Rd_En = 1'b0;
    ex = exp_q.pop_front();
    ad = addr_q.pop_front();
    chk($sformatf("rd[%0d]", ad), int'(Rd_Data), ex);
  endtask

  task automatic arm(int mode, int level, int decim, int wv, int pre,
                     output int s);
    Trig_Mode = 2'(mode);
    Trig_Level = DW'(level);
    Decim = DCW'(decim);
    Pre_Cnt = AW'(pre);
    @(posedge Clk); #1;
    s = cyc;
    t_base = s;
    wave_kind = wv;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic run_scen(scen_t sc);
    int s, step, pre_eff, jt, base, st, xj, xp, last;
    bit seen, rs, fl, hit;
    done_rises = 0;
    arm(sc.mode, sc.level, sc.decim, sc.wave, sc.pre, s);
    chk({sc.name, ".busy_on"}, int'(Busy), 1);
    chk({sc.name, ".done_clr"}, int'(Done), 0);
    step = sc.decim + 1;
    pre_eff = PRE ? sc.pre : 0;
    jt = -1;
    for (int j = 0; j < 20000 && jt < 0; j++) begin
      xj = wave(s + 1 + sc.decim + j * step);
      xp = (j > 0) ? wave(s + 1 + sc.decim + (j - 1) * step) : 0;
      rs = (j > 0) && (xp < sc.level) && (xj >= sc.level);
      fl = (j > 0) && (xp >= sc.level) && (xj < sc.level);
      hit = (sc.mode == 0) ? 1'b1 : (sc.mode == 2) ? fl : rs;
      if (hit && j >= pre_eff) jt = j;
    end
    seen = 1'b0;
    for (int i = 0; i < 40000 && !seen; i++) begin
      @(posedge Clk); #1;
      Start = sc.inj && (i == 500);
      if (Done) seen = 1'b1;
    end
    Start = 1'b0;
    chk({sc.name, ".done_seen"}, int'(seen), 1);
    if (!seen) return;
    chk({sc.name, ".busy_at_done"}, int'(Busy), 0);
    if (sc.inj) begin
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    repeat (4) @(posedge Clk);
    #1;
    chk({sc.name, ".busy_end"}, int'(Busy), sc.exp_busy);
    chk({sc.name, ".done_end"}, int'(Done), sc.exp_done);
    chk({sc.name, ".done_rises"}, done_rises, sc.exp_rises);
    base = PRE ? jt - pre_eff : jt;
    st = PRE ? ((jt - pre_eff) & (DEPTH - 1)) : 0;
    chk({sc.name, ".start_addr"}, int'(Start_Addr), st);
    last = 0;
    for (int a = 0; a < DEPTH; a++) begin
      last = wave(s + 1 + sc.decim +
                  (base + ((a - st) & (DEPTH - 1))) * step);
      do_read(a, last);
    end
    Rd_Addr = AW'(5);
    @(posedge Clk); #1;
    chk({sc.name, ".rd_hold"}, int'(Rd_Data), last);
  endtask

  initial begin
    int s;
    Reset = 1'b1;
    Start = 1'b0;
    Trig_Mode = '0;
    Trig_Level = '0;
    Decim = '0;
    Pre_Cnt = '0;
    Rd_En = 1'b0;
    Rd_Addr = '0;
    ADC_Data = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst.busy", int'(Busy), 0);
    chk("rst.done", int'(Done), 0);
    chk("rst.start_addr", int'(Start_Addr), 0);
    chk("rst.rd_data", int'(Rd_Data), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    chk("idle.busy", int'(Busy), 0);

    tbl[0] = '{"imm_ramp", 0, 0, 0, 0, 0, 1'b0, 0, 1, 1};
    tbl[1] = '{"rise_sine", 1, 8192, 0, 1, 0, 1'b0, 0, 1, 1};
    tbl[2] = '{"fall_ramp_d3", 2, 12000, 3, 2, 0, 1'b0, 0, 1, 1};
    tbl[3] = '{"mode3_sine_d1", 3, 5000, 1, 1, 0, 1'b0, 0, 1, 1};
    tbl[4] = '{"pre256_ramp", 1, 8192, 0, 0, 256, 1'b0, 0, 1, 1};
    tbl[5] = '{"start_in_capt_fin", 0, 0, 0, 0, 0, 1'b1, 0, 1, 1};
    for (int k = 0; k < 6; k++) run_scen(tbl[k]);

    // flat input never crosses: stays armed, ignores Start, reset aborts
    arm(1, 8192, 0, 3, 0, s);
    repeat (3000) @(posedge Clk);
    #1;
    chk("flat.busy", int'(Busy), 1);
    chk("flat.done", int'(Done), 0);
    Trig_Mode = 2'b00;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (1100) @(posedge Clk);
    #1;
    chk("flat.restart_busy", int'(Busy), 1);
    chk("flat.restart_done", int'(Done), 0);
    Reset = 1'b1;
    #1;
    chk("flat.rst_busy", int'(Busy), 0);
    chk("flat.rst_done", int'(Done), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("flat.after_rst_busy", int'(Busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
